// File: rtl/uart_wb_master_pkg.sv
// Shared constants for the UART-to-Wishbone bridge: frame FSM states,
// command/response bytes and the response-length helper.
package uart_wb_master_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_BUS  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  // Writes and errors answer with one byte, successful reads with four.
  function automatic logic [2:0] resp_len(input logic is_wr, input logic is_err);
    return (is_wr || is_err) ? 3'd1 : 3'd4;
  endfunction

endpackage

// File: rtl/uart_wb_master_serdes.sv
// 8N1 UART receiver/transmitter for the bridge: input synchronizer, mid-bit
// sampling RX with byte-valid / framing-error pulses, and a load/ready TX shifter.
module uart_wb_master_serdes #(
  parameter logic [7:0] CLK_DIV = 8'd104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic [7:0] rx_data,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);

  localparam logic [7:0] BIT_LAST  = CLK_DIV - 8'd1;
  localparam logic [7:0] HALF_LAST = (CLK_DIV >> 1) - 8'd1;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic       rx_s1, rx_s2, rx_prev;
  logic [1:0] rx_st;
  logic [7:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;

  logic [9:0] tx_sh;
  logic [7:0] tx_cnt;
  logic [3:0] tx_bits;
  logic       tx_busy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_st    <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= ser_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_st)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_st  <= RX_START;
          rx_cnt <= '0;
        end
        RX_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 8'd1;
        RX_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= RX_STOP;
        end else rx_cnt <= rx_cnt + 8'd1;
        default: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_valid <= rx_s2;
          rx_ferr  <= !rx_s2;
          rx_st    <= RX_IDLE;
        end else rx_cnt <= rx_cnt + 8'd1;
      endcase
    end
  end

  assign rx_data = rx_sh;

  // Ready is also raised in the last stop-bit cycle so a new start bit can follow directly.
  assign tx_ready = !tx_busy || (tx_bits == 4'd9 && tx_cnt == BIT_LAST);
  assign ser_tx   = tx_sh[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b0;
    end else if (tx_load && tx_ready) begin
      tx_sh   <= {1'b1, tx_data, 1'b0};
      tx_cnt  <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt  <= '0;
        tx_sh   <= {1'b1, tx_sh[9:1]};
        tx_bits <= tx_bits + 4'd1;
        if (tx_bits == 4'd9) tx_busy <= 1'b0;
      end else tx_cnt <= tx_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/uart_wb_master.sv
// Serial-to-Wishbone bridge top: frame FSM, address/data shifters and bus drive.
// Optional bus timeout is built when UART_WB_MASTER_TIMEOUT_EN is defined.
module uart_wb_master #(
  parameter logic [7:0]  CLK_DIV = 8'd104,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);
  import uart_wb_master_pkg::*;

  logic [2:0]  state;
  logic [1:0]  byte_cnt;
  logic        is_wr, is_err;
  logic [31:0] rdata;
  logic [2:0]  resp_idx;
  logic        rx_valid, rx_ferr, tx_load, tx_ready, timed_out;
  logic [7:0]  rx_data, tx_data;

  uart_wb_master_serdes #(.CLK_DIV(CLK_DIV)) u_serdes (
    .clk(wb_clk_i), .rst(wb_rst_i), .ser_rx(ser_rx), .ser_tx(ser_tx),
    .rx_valid(rx_valid), .rx_ferr(rx_ferr), .rx_data(rx_data),
    .tx_load(tx_load), .tx_data(tx_data), .tx_ready(tx_ready)
  );

`ifdef UART_WB_MASTER_TIMEOUT_EN
  logic [15:0] to_cnt;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)               to_cnt <= '0;
    else if (state != ST_BUS)   to_cnt <= '0;
    else                        to_cnt <= to_cnt + 16'd1;
  end
  assign timed_out = (to_cnt == TIMEOUT - 16'd1);
`else
  assign timed_out = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tx_load = (state == ST_RESP) && tx_ready && (resp_idx != resp_len(is_wr, is_err));
    tx_data = RSP_OK;
    if (is_err)      tx_data = RSP_ERR;
    else if (!is_wr) begin
      case (resp_idx[1:0])
        2'd0:    tx_data = rdata[31:24];
        2'd1:    tx_data = rdata[23:16];
        2'd2:    tx_data = rdata[15:8];
        default: tx_data = rdata[7:0];
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      is_wr     <= 1'b0;
      is_err    <= 1'b0;
      rdata     <= '0;
      resp_idx  <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
          is_wr    <= (rx_data == CMD_WR);
          is_err   <= 1'b0;
          byte_cnt <= '0;
          state    <= ST_ADDR;
        end
        ST_ADDR, ST_DATA: begin
          if (rx_ferr) state <= ST_IDLE;
          else if (rx_valid) begin
            if (state == ST_ADDR) wbm_adr_o <= {wbm_adr_o[23:0], rx_data};
            else                  wbm_dat_o <= {wbm_dat_o[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (state == ST_ADDR && is_wr) state <= ST_DATA;
              else begin
                state     <= ST_BUS;
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= is_wr;
                wbm_sel_o <= 4'hF;
              end
            end
          end
        end
        ST_BUS: if (wbm_ack_i || timed_out) begin
          // Ack has priority over a timeout reached in the same cycle.
          if (wbm_ack_i) rdata <= wbm_dat_i;
          is_err    <= !wbm_ack_i;
          resp_idx  <= '0;
          state     <= ST_RESP;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          wbm_sel_o <= '0;
        end
        ST_RESP: begin
          if (tx_load) resp_idx <= resp_idx + 3'd1;
          else if (tx_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
